sc_datamem_io: RTL and testbench

Parametrised data-memory and memory-mapped I/O block for the single-cycle CPU: a word-addressed data RAM with byte-lane writes, N registered output ports, and N synchronised input ports with sticky change detection and a maskable interrupt. It serves CPU loads/stores over one request interface with a registered, one-cycle read latency. It replaces the fixed two-input/three-output data memory in the CPU's data path.

---
 rtl/sc_datamem_io_pkg.sv | 21 ++
 rtl/sc_datamem_io_if.sv | 26 ++
 rtl/sc_datamem_io_dmem_ram.sv | 44 ++++
 rtl/sc_datamem_io.sv | 151 +++++++++++++++
 tb/tb_sc_datamem_io.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/sc_datamem_io_pkg.sv
// rtl/sc_datamem_io_pkg.sv - shared constants and region decode for sc_datamem_io
// Purpose: I/O register map indices, the address bit that selects RAM vs I/O,
//          and the region-decode helper used by the top level.
package sc_datamem_io_pkg;

  localparam int OUT_BASE   = 0;   // OUT[k] at word index OUT_BASE+k
  localparam int IN_BASE    = 8;   // IN[k] at word index IN_BASE+k
  localparam int CHG_IDX    = 16;  // sticky change flags, write-1-to-clear
  localparam int MASK_IDX   = 17;  // interrupt mask
  localparam int IO_SEL_BIT = 7;   // byte-address bit selecting the I/O window

  typedef enum logic {
    REGION_RAM = 1'b0,
    REGION_IO  = 1'b1
  } region_e;

  function automatic region_e decode_region(input logic [31:0] addr);
    return addr[IO_SEL_BIT] ? REGION_IO : REGION_RAM;
  endfunction

endpackage

// File: rtl/sc_datamem_io_if.sv
// rtl/sc_datamem_io_if.sv - CPU load/store request interface
// Purpose: groups the CPU-side request and load-response signals.
// Signals: req/we/be/addr/wdata from the CPU, rdata/rvalid back to it.
interface sc_datamem_io_if #(
  parameter int DATA_W = 32
);

  logic                  req;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [31:0]           addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;

  modport master (
    output req, we, be, addr, wdata,
    input  rdata, rvalid
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output rdata, rvalid
  );

endinterface

// File: rtl/sc_datamem_io_dmem_ram.sv
// rtl/sc_datamem_io_dmem_ram.sv - single-port byte-enabled RAM with registered read
// Purpose: data RAM behind the CPU port; array contents are not reset.
// Ports: clock, resetn (read register only), en/we/be/idx/wdata request,
//        rdata registered load result that holds until the next load.
module sc_datamem_io_dmem_ram #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clock) begin
    if (en && we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem_q[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem_q[idx];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sc_datamem_io.sv
// rtl/sc_datamem_io.sv - data RAM plus memory-mapped I/O ports for the CPU
// Purpose: decodes CPU loads/stores to the data RAM or the I/O window, holds
//          output port registers, synchronises input ports with sticky change
//          flags and a maskable interrupt, and returns loads one cycle later.
// Ports: clock, resetn (async, active low), bus (slave side of the CPU
//        interface), in_port (async inputs), out_port (registered outputs), irq.
module sc_datamem_io
  import sc_datamem_io_pkg::*;
#(
  parameter int              DATA_W     = 32,
  parameter int              DEPTH_LOG2 = 5,
  parameter int              N_IN       = 2,
  parameter int              N_OUT      = 3,
  parameter logic [DATA_W-1:0] OUT_RST  = '0
) (
  input  logic                    clock,
  input  logic                    resetn,
  sc_datamem_io_if.slave          bus,
  input  logic [N_IN*DATA_W-1:0]  in_port,
  output logic [N_OUT*DATA_W-1:0] out_port,
  output logic                    irq
);

  localparam int NB = DATA_W / 8;

  region_e               region;
  logic [4:0]            io_idx;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                  ram_en, io_wr, io_rd;
  logic [DATA_W-1:0]     ram_rdata, io_rval;
  logic                  unused_addr;

  logic [DATA_W-1:0] out_q [N_OUT];
  logic [DATA_W-1:0] out_d [N_OUT];
  logic [DATA_W-1:0] sync1_q [N_IN];
  logic [DATA_W-1:0] sync1_d [N_IN];
  logic [DATA_W-1:0] sync2_q [N_IN];
  logic [DATA_W-1:0] sync2_d [N_IN];
  logic [DATA_W-1:0] prev_q  [N_IN];
  logic [DATA_W-1:0] prev_d  [N_IN];
  logic [N_IN-1:0]   chg_q, chg_d, mask_q, mask_d, chg_set, chg_clr;
  logic              irq_q, irq_d, rvalid_q, rvalid_d, rd_io_q, rd_io_d;
  logic [DATA_W-1:0] io_rdata_q, io_rdata_d;

  assign region      = decode_region(bus.addr);
  assign io_idx      = bus.addr[6:2];
  assign ram_idx     = bus.addr[DEPTH_LOG2+1:2];
  assign ram_en      = bus.req && (region == REGION_RAM);
  assign io_wr       = bus.req &&  bus.we && (region == REGION_IO);
  assign io_rd       = bus.req && !bus.we && (region == REGION_IO);
  assign unused_addr = ^bus.addr;

  sc_datamem_io_dmem_ram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clock  (clock),
    .resetn (resetn),
    .en     (ram_en),
    .we     (bus.we),
    .be     (bus.be),
    .idx    (ram_idx),
    .wdata  (bus.wdata),
    .rdata  (ram_rdata)
  );

  // I/O read mux; unmapped indices fall through to zero.
  always_comb begin
    io_rval = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (io_idx == 5'(OUT_BASE + k)) io_rval = out_q[k];
    end
    for (int k = 0; k < N_IN; k++) begin
      if (io_idx == 5'(IN_BASE + k)) io_rval = sync2_q[k];
    end
    if (io_idx == 5'(CHG_IDX))  io_rval = DATA_W'(chg_q);
    if (io_idx == 5'(MASK_IDX)) io_rval = DATA_W'(mask_q);
  end

  always_comb begin
    rvalid_d   = bus.req && !bus.we;
    rd_io_d    = rd_io_q;
    io_rdata_d = io_rdata_q;
    // Remember which source answered the last load so rdata holds between loads.
    if (rvalid_d) rd_io_d = (region == REGION_IO);
    if (io_rd)    io_rdata_d = io_rval;

    out_d = out_q;
    for (int k = 0; k < N_OUT; k++) begin
      for (int b = 0; b < NB; b++) begin
        if (io_wr && io_idx == 5'(OUT_BASE + k) && bus.be[b])
          out_d[k][b*8 +: 8] = bus.wdata[b*8 +: 8];
      end
    end

    chg_clr = '0;
    mask_d  = mask_q;
    if (io_wr && bus.be[0]) begin
      if (io_idx == 5'(CHG_IDX))  chg_clr = bus.wdata[N_IN-1:0];
      if (io_idx == 5'(MASK_IDX)) mask_d  = bus.wdata[N_IN-1:0];
    end

    chg_set = '0;
    for (int k = 0; k < N_IN; k++) begin
      sync1_d[k] = in_port[k*DATA_W +: DATA_W];
      sync2_d[k] = sync1_q[k];
      prev_d[k]  = sync2_q[k];
      chg_set[k] = (sync2_q[k] != prev_q[k]);
    end
    // A fresh change beats a simultaneous clear.
    chg_d = (chg_q & ~chg_clr) | chg_set;
    irq_d = |(chg_q & mask_q);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= OUT_RST;
      for (int k = 0; k < N_IN; k++) begin
        sync1_q[k] <= '0;
        sync2_q[k] <= '0;
        prev_q[k]  <= '0;
      end
      chg_q      <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      rd_io_q    <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      out_q      <= out_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      chg_q      <= chg_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
      rvalid_q   <= rvalid_d;
      rd_io_q    <= rd_io_d;
      io_rdata_q <= io_rdata_d;
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign out_port[k*DATA_W +: DATA_W] = out_q[k];
  end

  assign bus.rdata  = rd_io_q ? io_rdata_q : ram_rdata;
  assign bus.rvalid = rvalid_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_sc_datamem_io.sv
// tb/tb_sc_datamem_io.sv - self-checking bench for sc_datamem_io
module tb_sc_datamem_io;

  localparam int DW = 32;
  localparam int DL = 5;
  localparam int NI = 2;
  localparam int NO = 3;
  localparam logic [31:0] ORST = 32'hA5A5_0000;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  sc_datamem_io_if #(.DATA_W(DW)) bus ();
  logic [NI*DW-1:0] in_port;
  logic [NO*DW-1:0] out_port;
  logic             irq;

  sc_datamem_io #(
    .DATA_W(DW), .DEPTH_LOG2(DL), .N_IN(NI), .N_OUT(NO), .OUT_RST(ORST)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .bus      (bus),
    .in_port  (in_port),
    .out_port (out_port),
    .irq      (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural state plus a history of sampled inputs.
  logic [31:0] m_ram [32];
  logic [31:0] m_out [NO];
  logic [NI-1:0] m_chg, m_mask;
  logic        m_irq, m_rvalid;
  logic [31:0] m_rdata;
  // h1: input seen at the last edge, h2: at the edge before (visible value), h3: one earlier.
  logic [NI*DW-1:0] h1, h2, h3;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int idx;
    idx = int'(a[6:2]);
    if (!a[7]) return m_ram[idx];
    if (idx < NO) return m_out[idx];
    if (idx >= 8 && idx < 8 + NI) return h2[(idx-8)*DW +: DW];
    if (idx == 16) return 32'(m_chg);
    if (idx == 17) return 32'(m_mask);
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NO; k++) m_out[k] = ORST;
    m_chg = '0; m_mask = '0; m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    h1 = '0; h2 = '0; h3 = '0;
  endtask

  task automatic model_edge();
    logic [NI-1:0] set, clr;
    logic [31:0]   rd;
    logic          irq_n;
    int            idx;
    for (int k = 0; k < NI; k++) set[k] = (h2[k*DW +: DW] != h3[k*DW +: DW]);
    rd    = m_read(bus.addr);
    irq_n = |(m_chg & m_mask);
    clr   = '0;
    idx   = int'(bus.addr[6:2]);
    if (bus.req && bus.we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.be[b]) begin
          if (!bus.addr[7]) m_ram[idx][b*8 +: 8] = bus.wdata[b*8 +: 8];
          else if (idx < NO) m_out[idx][b*8 +: 8] = bus.wdata[b*8 +: 8];
        end
      end
      if (bus.addr[7] && bus.be[0] && idx == 16) clr = bus.wdata[NI-1:0];
      if (bus.addr[7] && bus.be[0] && idx == 17) m_mask = bus.wdata[NI-1:0];
    end
    m_chg    = (m_chg & ~clr) | set;
    m_irq    = irq_n;
    m_rvalid = bus.req && !bus.we;
    if (m_rvalid) m_rdata = rd;
    h3 = h2; h2 = h1; h1 = in_port;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    chk("rvalid", 128'(bus.rvalid), 128'(m_rvalid));
    chk("rdata", 128'(bus.rdata), 128'(m_rdata));
    chk("out_port", 128'(out_port), 128'({m_out[2], m_out[1], m_out[0]}));
    chk("irq", 128'(irq), 128'(m_irq));
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    bus.req = r; bus.we = w; bus.be = b; bus.addr = a; bus.wdata = d;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    drive(1'b1, 1'b1, b, a, d); tick();
  endtask

  task automatic load(input logic [31:0] a);
    drive(1'b1, 1'b0, 4'h0, a, $urandom); tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); tick();
  endtask

  initial begin
    in_port = '0;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    model_reset();
    #12;
    chk("rst_rvalid", 128'(bus.rvalid), 128'(0));
    chk("rst_rdata", 128'(bus.rdata), 128'(0));
    chk("rst_out", 128'(out_port), 128'({ORST, ORST, ORST}));
    chk("rst_irq", 128'(irq), 128'(0));
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 32; i++) store(32'(i * 4), $urandom, 4'hF);

    // Byte-lane merge and one-cycle load latency.
    store(32'h04, 32'hDEAD_BEEF, 4'hF);
    store(32'h04, 32'h0000_00AA, 4'h1);
    load(32'h04);
    chk("t1_rvalid", 128'(bus.rvalid), 128'(1));
    chk("t1_rdata", 128'(bus.rdata), 128'(32'hDEAD_BEAA));
    idle();
    chk("t1_rvalid_drop", 128'(bus.rvalid), 128'(0));
    chk("t1_rdata_hold", 128'(bus.rdata), 128'(32'hDEAD_BEAA));

    // Output ports, and an unimplemented OUT index.
    store(32'h80, 32'h1234_5678, 4'hF);
    store(32'h88, 32'h1234_5678, 4'hF);
    chk("t2_out0", 128'(out_port[31:0]), 128'(32'h1234_5678));
    chk("t2_out1", 128'(out_port[63:32]), 128'(ORST));
    chk("t2_out2", 128'(out_port[95:64]), 128'(32'h1234_5678));
    store(32'h8C, 32'hFFFF_FFFF, 4'hF);
    load(32'h8C);
    chk("t2_out3_rd", 128'(bus.rdata), 128'(0));

    // Input change detection latency.
    in_port[63:32] = 32'h55;
    idle(); idle();
    load(32'hC0);
    chk("t3_chg_early", 128'(bus.rdata), 128'(0));
    load(32'hC0);
    chk("t3_chg", 128'(bus.rdata), 128'(2));
    load(32'hA4);
    chk("t3_in1", 128'(bus.rdata), 128'(32'h55));
    chk("t3_irq_masked", 128'(irq), 128'(0));

    // Mask, clear, and set-wins-over-clear.
    store(32'hC4, 32'h2, 4'h1);
    idle();
    chk("t4_irq_on", 128'(irq), 128'(1));
    store(32'hC0, 32'h2, 4'h1);
    idle();
    chk("t4_irq_off", 128'(irq), 128'(0));
    load(32'hC0);
    chk("t4_chg_clr", 128'(bus.rdata), 128'(0));
    in_port[63:32] = 32'hAA;
    idle(); idle();
    store(32'hC0, 32'h2, 4'h1);
    load(32'hC0);
    chk("t4_set_wins", 128'(bus.rdata), 128'(2));
    store(32'hC0, 32'h3, 4'h1);
    store(32'hC4, 32'h0, 4'h1);

    // Back-to-back loads.
    load(32'h00);
    chk("t5_v0", 128'(bus.rvalid), 128'(1));
    chk("t5_d0", 128'(bus.rdata), 128'(m_ram[0]));
    load(32'h04);
    chk("t5_v1", 128'(bus.rvalid), 128'(1));
    chk("t5_d1", 128'(bus.rdata), 128'(32'hDEAD_BEAA));
    load(32'h80);
    chk("t5_v2", 128'(bus.rvalid), 128'(1));
    chk("t5_d2", 128'(bus.rdata), 128'(32'h1234_5678));

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      if ($urandom_range(1, 0) == 0) a = {24'h0, 1'b0, 5'($urandom), 2'($urandom)};
      else                           a = {24'h0, 1'b1, 5'($urandom), 2'($urandom)};
      if ($urandom_range(7, 0) == 0) in_port[$urandom_range(1, 0)*DW +: DW] = $urandom;
      drive(1'($urandom), 1'($urandom), 4'($urandom), a, $urandom);
      tick();
    end

    // Asynchronous reset in the middle of a load.
    store(32'h80, 32'h1234_5678, 4'hF);
    store(32'hC4, 32'h3, 4'h1);
    in_port[31:0] = ~in_port[31:0];
    for (int i = 0; i < 5; i++) idle();
    chk("t6_irq_pre", 128'(irq), 128'(1));
    drive(1'b1, 1'b0, 4'h0, 32'h04, 32'h0);
    @(posedge clock);
    model_edge();
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    chk("t6_rvalid", 128'(bus.rvalid), 128'(0));
    chk("t6_out", 128'(out_port), 128'({ORST, ORST, ORST}));
    chk("t6_irq", 128'(irq), 128'(0));
    chk("t6_rdata", 128'(bus.rdata), 128'(0));
    in_port = '0;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    load(32'hC0);
    chk("t6_chg", 128'(bus.rdata), 128'(0));
    load(32'hC4);
    chk("t6_mask", 128'(bus.rdata), 128'(0));
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
